// File: rtl/utlb_lookup.sv
// Multi-port TLB lookup: a private fully-associative micro-TLB per port, with misses
// served by one shared main-TLB comparator behind a round-robin arbiter.
package utlb_pkg;
  // Width of the main-entry index carried in results (covers up to 16 main entries).
  localparam int TLB_IDX_W = 4;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic        d0;
    logic        v0;
    logic [2:0]  c0;
    logic [19:0] pfn1;
    logic        d1;
    logic        v1;
    logic [2:0]  c1;
  } tlb_entry_t;

  typedef struct packed {
    logic                 miss;
    logic [TLB_IDX_W-1:0] which;
    logic [31:0]          phy_addr;
    logic                 dirty;
    logic                 valid;
    logic [2:0]           cache_flag;
  } tlb_result_t;
endpackage

// state  | meaning
// S_IDLE | ready; request checked against the micro-TLB this cycle
// S_WAIT | micro miss or flush; waiting for a main-comparator grant
module utlb_lookup
  import utlb_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_PORTS   = 2,
  parameter int UTLB_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  tlb_entry_t  [NUM_ENTRIES-1:0]       entries,
  input  logic [7:0]                          asid,
  input  logic                                flush,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0][31:0]          req_vaddr,
  output logic [NUM_PORTS-1:0]                resp_valid,
  output tlb_result_t [NUM_PORTS-1:0]         resp
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int VW    = (UTLB_DEPTH > 1) ? $clog2(UTLB_DEPTH) : 1;
  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  function automatic logic ent_match(tlb_entry_t e, logic [18:0] vpn2, logic [7:0] cur_asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == cur_asid));
  endfunction

  function automatic tlb_result_t ent_result(tlb_entry_t e, logic [TLB_IDX_W-1:0] idx,
                                             logic [31:0] va, logic miss);
    tlb_result_t r;
    r.miss  = miss;
    r.which = idx;
    if (va[12]) begin
      r.phy_addr = {e.pfn1, va[11:0]};
      r.dirty = e.d1; r.valid = e.v1; r.cache_flag = e.c1;
    end else begin
      r.phy_addr = {e.pfn0, va[11:0]};
      r.dirty = e.d0; r.valid = e.v0; r.cache_flag = e.c0;
    end
    return r;
  endfunction

  logic [NUM_PORTS-1:0]                              state_q, state_d;
  logic [NUM_PORTS-1:0][31:0]                        vaddr_q, vaddr_d;
  logic [NUM_PORTS-1:0]                              resp_valid_q, resp_valid_d;
  tlb_result_t [NUM_PORTS-1:0]                       resp_q, resp_d;
  logic [NUM_PORTS-1:0][UTLB_DEPTH-1:0]              uv_q, uv_d;
  tlb_entry_t [NUM_PORTS-1:0][UTLB_DEPTH-1:0]        ue_q, ue_d;
  logic [NUM_PORTS-1:0][UTLB_DEPTH-1:0][TLB_IDX_W-1:0] ui_q, ui_d;
  logic [NUM_PORTS-1:0][VW-1:0]                      victim_q, victim_d;
  logic [PTR_W-1:0]                                  rr_q, rr_d;

  logic [NUM_PORTS-1:0]        u_hit;
  tlb_result_t [NUM_PORTS-1:0] u_res;
  logic [NUM_PORTS-1:0]        gnt;
  logic                        gnt_any;
  logic [PTR_W-1:0]            gnt_idx;
  logic [31:0]                 gnt_vaddr;
  logic                        main_hit;
  logic [TLB_IDX_W-1:0]        main_idx;
  tlb_result_t                 main_res;

  always_comb begin
    u_hit = '0;
    u_res = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int d = 0; d < UTLB_DEPTH; d++) begin
        if (uv_q[p][d] && ent_match(ue_q[p][d], req_vaddr[p][31:13], asid)) begin
          u_hit[p] = 1'b1;
          u_res[p] = ent_result(ue_q[p][d], ui_q[p][d], req_vaddr[p], 1'b0);
        end
      end
    end
  end

  // Round-robin search starting at rr_q; first waiting port wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!gnt_any && state_q[j] == S_WAIT) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    rr_d = rr_q;
    if (gnt_any) rr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Later matches overwrite earlier ones, so the highest index wins; a miss reports entry 0.
  always_comb begin
    gnt_vaddr = vaddr_q[gnt_idx];
    main_hit  = 1'b0;
    main_idx  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_match(entries[i], gnt_vaddr[31:13], asid)) begin
        main_hit = 1'b1;
        main_idx = TLB_IDX_W'(i);
      end
    end
    main_res = ent_result(entries[main_idx], main_idx, gnt_vaddr, !main_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      case (state_q[p])
        S_IDLE:  if (req_valid[p] && (!u_hit[p] || flush)) state_d[p] = S_WAIT;
        default: if (gnt[p]) state_d[p] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) req_ready[p] = (state_q[p] == S_IDLE);
  end

  always_comb begin
    vaddr_d      = vaddr_q;
    resp_valid_d = '0;
    resp_d       = resp_q;
    uv_d         = uv_q;
    ue_d         = ue_q;
    ui_d         = ui_q;
    victim_d     = victim_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state_q[p] == S_IDLE && req_valid[p]) begin
        if (u_hit[p] && !flush) begin
          resp_valid_d[p] = 1'b1;
          resp_d[p]       = u_res[p];
        end else begin
          vaddr_d[p] = req_vaddr[p];
        end
      end
      if (gnt[p]) begin
        resp_valid_d[p] = 1'b1;
        resp_d[p]       = main_res;
        if (!main_res.miss && !flush) begin
          uv_d[p][victim_q[p]] = 1'b1;
          ue_d[p][victim_q[p]] = entries[main_idx];
          ui_d[p][victim_q[p]] = main_idx;
          victim_d[p] = (victim_q[p] == VW'(UTLB_DEPTH - 1)) ? '0 : victim_q[p] + 1'b1;
        end
      end
    end
    if (flush) uv_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vaddr_q      <= '0;
      resp_valid_q <= '0;
      resp_q       <= '0;
      uv_q         <= '0;
      ue_q         <= '0;
      ui_q         <= '0;
      victim_q     <= '0;
      rr_q         <= '0;
    end else begin
      vaddr_q      <= vaddr_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      uv_q         <= uv_d;
      ue_q         <= ue_d;
      ui_q         <= ui_d;
      victim_q     <= victim_d;
      rr_q         <= rr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;
endmodule

// File: tb/tb_utlb_lookup.sv
// Self-checking bench for utlb_lookup: vector table plus hand-written arbitration,
// flush and reset sequences; responses are matched against a per-port scoreboard.
module tb_utlb_lookup;
  import utlb_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  tlb_entry_t [15:0]      entries;
  logic [7:0]             asid;
  logic                   flush;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][31:0]       req_vaddr;
  logic [1:0]             resp_valid;
  tlb_result_t [1:0]      resp;

  utlb_lookup #(.NUM_ENTRIES(16), .NUM_PORTS(2), .UTLB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .entries(entries), .asid(asid), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .resp_valid(resp_valid), .resp(resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; tlb_result_t res; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  typedef struct { int port; logic [31:0] va; int lat; tlb_result_t exp; } vec_t;
  vec_t vt[21];

  function automatic tlb_result_t mkres(bit miss, int which, logic [31:0] pa, bit d, bit v, int cf);
    tlb_result_t r;
    r.miss = miss; r.which = 4'(which); r.phy_addr = pa;
    r.dirty = d; r.valid = v; r.cache_flag = 3'(cf);
    return r;
  endfunction

  function automatic tlb_entry_t mkent(int vpn2, int a, bit g, int pfn0, bit d0, bit v0, int c0,
                                       int pfn1, bit d1, bit v1, int c1);
    tlb_entry_t e;
    e.vpn2 = 19'(vpn2); e.asid = 8'(a); e.g = g;
    e.pfn0 = 20'(pfn0); e.d0 = d0; e.v0 = v0; e.c0 = 3'(c0);
    e.pfn1 = 20'(pfn1); e.d1 = d1; e.v1 = v1; e.c1 = 3'(c1);
    return e;
  endfunction

  function automatic vec_t mkv(int p, logic [31:0] va, int lat, tlb_result_t r);
    vec_t v;
    v.port = p; v.va = va; v.lat = lat; v.exp = r;
    return v;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (resp_valid[p] === 1'b1) begin
        checks++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_resp port%0d cyc %0d got %h want no response", p, cyc, resp[p]);
        end else begin
          if (p == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          if (mon_e.due != cyc || resp[p] !== mon_e.res) begin
            errors++;
            $display("FAIL resp_port%0d got cyc %0d res %h want cyc %0d res %h",
                     p, cyc, resp[p], mon_e.due, mon_e.res);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input int p, input int lat, input tlb_result_t r);
    exp_t e;
    e.due = cyc + lat;
    e.res = r;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk); #1;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d/%0d want 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic req1(input int p, input logic [31:0] va, input int lat, input tlb_result_t r);
    @(negedge clk);
    req_vaddr[p] = va;
    req_valid[p] = 1'b1;
    push(p, lat, r);
    @(negedge clk);
    req_valid = '0;
    drain();
  endtask

  task automatic req2(input logic [31:0] va0, input int l0, input tlb_result_t r0,
                      input logic [31:0] va1, input int l1, input tlb_result_t r1);
    @(negedge clk);
    req_vaddr[0] = va0;
    req_vaddr[1] = va1;
    req_valid    = 2'b11;
    push(0, l0, r0);
    push(1, l1, r1);
    @(negedge clk);
    req_valid = '0;
    drain();
  endtask

  task automatic flush_pulse(input logic [7:0] new_asid);
    @(negedge clk);
    asid  = new_asid;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) req1(vt[i].port, vt[i].va, vt[i].lat, vt[i].exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tlb_result_t res3, res7, res_k[5];

    for (int i = 0; i < 16; i++) entries[i] = mkent(19'h7FFFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    entries[0] = mkent(19'h7FFFF, 8'hFF, 0, 20'hDEAD0, 1, 0, 2, 20'hBEEF1, 0, 1, 4);
    entries[3] = mkent(19'h00040, 5, 0, 20'h12345, 0, 1, 3, 20'h0, 0, 0, 0);
    entries[4] = mkent(19'h00100, 5, 0, 20'h11111, 1, 1, 2, 20'h0, 0, 0, 0);
    entries[7] = mkent(19'h00001, 9, 1, 20'h0, 0, 0, 0, 20'h00ABC, 1, 1, 5);
    entries[9] = mkent(19'h00100, 5, 0, 20'h99999, 1, 1, 2, 20'h0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      entries[11+k] = mkent(19'h00200 + k, 0, 1, 20'h30000 + k, 0, 1, 1, 20'h0, 0, 0, 0);
      res_k[k] = mkres(0, 11 + k, (32'h30000 + k) << 12, 0, 1, 1);
    end
    res3 = mkres(0, 3, 32'h12345ABC, 0, 1, 3);
    res7 = mkres(0, 7, 32'h00ABC010, 1, 1, 5);

    vt[0]  = mkv(0, 32'h0008_0ABC, 2, res3);
    vt[1]  = mkv(0, 32'h0008_0ABC, 1, res3);
    vt[2]  = mkv(1, 32'h0008_0ABC, 2, res3);
    vt[3]  = mkv(1, 32'h0008_0ABC, 1, res3);
    vt[4]  = mkv(0, 32'h0020_0000, 2, mkres(0, 9, 32'h99999000, 1, 1, 2));
    vt[5]  = mkv(0, 32'h0020_0FFC, 1, mkres(0, 9, 32'h99999FFC, 1, 1, 2));
    vt[6]  = mkv(0, 32'h1234_0000, 2, mkres(1, 0, 32'hDEAD0000, 1, 0, 2));
    vt[7]  = mkv(0, 32'h1234_0000, 2, mkres(1, 0, 32'hDEAD0000, 1, 0, 2));
    vt[8]  = mkv(0, 32'h0008_0ABC, 2, mkres(0, 3, 32'h55555ABC, 0, 1, 3));
    vt[9]  = mkv(0, 32'h0008_0ABC, 1, mkres(0, 3, 32'h55555ABC, 0, 1, 3));
    vt[10] = mkv(0, 32'h0000_3010, 2, res7);
    vt[11] = mkv(0, 32'h0000_3010, 1, res7);
    vt[12] = mkv(1, 32'h0008_0ABC, 2, mkres(1, 0, 32'hDEAD0ABC, 1, 0, 2));
    for (int k = 0; k < 5; k++) vt[13+k] = mkv(1, 32'h0040_0000 + k * 32'h2000, 2, res_k[k]);
    vt[18] = mkv(1, 32'h0040_0000, 2, res_k[0]);
    vt[19] = mkv(1, 32'h0040_8000, 1, res_k[4]);
    vt[20] = mkv(1, 32'h0040_4000, 1, res_k[2]);

    rst = 1'b1; flush = 1'b0; asid = 8'd5; req_valid = '0; req_vaddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(2'b11));
    chk("rst_resp_valid", 128'(resp_valid), 128'(2'b00));
    chk("rst_resp", 128'(resp), 128'(0));
    rst = 1'b0;

    run_vecs(0, 8);
    flush_pulse(8'd5);
    entries[3].pfn0 = 20'h55555;
    run_vecs(8, 10);
    flush_pulse(8'd2);
    run_vecs(10, 13);
    flush_pulse(8'd2);
    run_vecs(13, 21);

    // Pointer is 0 here (last grant went to port 1), then 1 after a lone port-0 miss.
    flush_pulse(8'd2);
    req2(32'h0000_3010, 2, res7, 32'h0000_3010, 3, res7);
    req1(0, 32'h0040_2000, 2, res_k[1]);
    flush_pulse(8'd2);
    req2(32'h0000_3010, 3, res7, 32'h0000_3010, 2, res7);

    // Flush landing in the grant cycle: response still returned, nothing refilled.
    @(negedge clk);
    req_vaddr[0] = 32'h0040_4000;
    req_valid[0] = 1'b1;
    push(0, 2, res_k[2]);
    @(negedge clk);
    req_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drain();
    req1(0, 32'h0040_4000, 2, res_k[2]);
    req1(1, 32'h0000_3010, 2, res7);

    // Reset while port 0 waits for the main comparator: request is dropped.
    @(negedge clk);
    req_vaddr[0] = 32'h1234_0000;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 128'(resp_valid), 128'(2'b00));
    chk("midrst_req_ready", 128'(req_ready), 128'(2'b11));
    chk("midrst_resp", 128'(resp), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    req1(1, 32'h0000_3010, 2, res7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/utlb_lookup.md
# utlb_lookup

Multi-port TLB lookup front end: each of `NUM_PORTS` lookup channels (e.g. instruction fetch, data access) has a private fully-associative micro-TLB. A shared main-TLB comparator serves micro-TLB misses through a round-robin arbiter. Sits between the pipeline address stages and the MMU's TLB entry array. Returns `tlb_result_t` per request with registered outputs.

## Interface
- `NUM_ENTRIES`, 16: main TLB entries.
- `NUM_PORTS`, 2: lookup channels, ≥1.
- `UTLB_DEPTH`, 4: micro-TLB entries per port, ≥1.
- Reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `entries` in `NUM_ENTRIES` x `tlb_entry_t`: main TLB contents.
- `asid` in 8: current ASID.
- `flush` in 1: invalidate all micro-TLBs. Pulsed on TLBWI/TLBWR or an ASID change.
- `req_valid` in `NUM_PORTS`: lookup request per port.
- `req_ready` out `NUM_PORTS`: port can accept a request.
- `req_vaddr` in `NUM_PORTS` x 32: virtual address per port.
- `resp_valid` out `NUM_PORTS`: one-cycle response pulse. There is no backpressure on responses.
- `resp` out `NUM_PORTS` x `tlb_result_t`: the fields `miss`, `which`, `phy_addr`, `dirty`, `valid`, `cache_flag`.

## Operation
- **Entry match:** `vpn2 == vaddr[31:13]` and (`asid` equal or `G`).
  - If several main entries match, the highest index wins.
  - `which` = index of the winning main entry.
- **Page half:** `vaddr[12]` selects it. 1 uses `pfn1/d1/v1/c1`; 0 uses `pfn0/d0/v0/c0`.
- **Physical address:** `phy_addr[31:12]` = selected `pfn[19:0]`; `phy_addr[11:0]` = `vaddr[11:0]`.
- **Micro-TLB line:** valid bit, full `tlb_entry_t` copy, main index.
  - It is matched with the same rule against the live `asid`.
  - Page-half selection is the same as for the main TLB.
- **Per-port FSM:** IDLE, WAIT_MAIN.
  - IDLE:
    - `req_ready`=1.
    - On `req_valid`, the address is compared against the micro-TLB in the same cycle.
    - Hit and no `flush` that cycle: the result is registered, `resp_valid` goes high next cycle, and the FSM stays in IDLE.
    - Miss or `flush` that cycle: the vaddr is latched and the FSM goes to WAIT_MAIN.
  - WAIT_MAIN:
    - `req_ready`=0.
    - The port requests the main comparator.
    - When granted, the main lookup is done combinationally against the current `entries` and `asid`, the result is registered, and `resp_valid` fires next cycle.
    - Refill occurs if `miss`=0 and `flush`=0 in the grant cycle; the FSM then returns to IDLE.
- **Arbiter:**
  - Grants one port per cycle, round-robin.
  - The pointer moves to (granted+1) mod `NUM_PORTS` after each grant and is unchanged when there is no grant.
- **Refill:** writes the line at the per-port victim pointer, which then increments mod `UTLB_DEPTH`. The pointer is unaffected by flush.
- **Main miss** (`miss`=1): returned with `which`=0 and other fields from entry 0; nothing is refilled.
- **Flush:** clears all valid bits at the clock edge and has priority over a simultaneous refill. A WAIT_MAIN port continues and completes normally without refill.

## Timing
- **Reset:** all outputs and state are cleared.
  - `resp_valid`=0, `resp`=0, `req_ready`=1 (all ports IDLE).
  - Micro valid bits 0, victim pointers 0, arbiter pointer 0.
  - If reset is asserted mid-request, the request is dropped and no response is produced.
- **Micro hit:** 1 cycle latency (request accepted at edge N, `resp_valid` during cycle N+1). A port can issue a new request in the response cycle, so throughput is 1/cycle per port.
- **Micro miss:** the earliest response is cycle N+2 if granted at N+1. Each cycle of arbitration loss adds 1 cycle.
- **Worst-case miss:** latency ≤ `NUM_PORTS`+1 cycles.
- **`resp`:** holds its value until the next response on that port.
- **Micro-TLB contents:** sampled in the acceptance cycle. `entries`/`asid` are sampled in the grant cycle, with no extra registering.

## Test plan
- **Hit path:** entry 3 = {vpn2 0x00040, asid 5, pfn0 0x12345, v0 1, d0 0, c0 3}, `asid`=5. Port 0 requests 0x0008_0ABC → miss, response at N+2 with `phy_addr`=0x12345ABC, `which`=3, `valid`=1. Repeating the same address → response at N+1, same values.
- **Odd page + global:** entry 7 has `G`=1, `asid`=9, pfn1 0x00ABC. With `asid`=2, vaddr 0x0000_3010 → `phy_addr`=0x00ABC010, `miss`=0. A second lookup hits the micro-TLB with 1 cycle latency.
- **Arbitration:** both ports miss in the same cycle → port 0 responds at N+2, port 1 at N+3. Repeating the scenario → port 1 first (pointer=1).
- **Flush:** after the micro hit in the hit-path test, pulse `flush` and change entry 3 pfn0 to 0x55555. Re-request → response at 2-cycle latency with 0x55555ABC. A `flush` coincident with a grant leaves no valid lines.
- **Replacement and miss:** with `UTLB_DEPTH`=4, refill 5 distinct pages → the first page's line is evicted, so a re-lookup takes 2 cycles. An unmapped vaddr → `miss`=1, and a repeat still takes 2 cycles.
- **Reset mid-miss:** assert `rst` while a port is in WAIT_MAIN → `resp_valid`=0, `req_ready`=1, and no response after deassertion.
